// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - passive checker for the up/down counter's value and complement outputs
// Predicts each sample from the previous cycle's observed value and command, so it resyncs after a fault.
module counter_checker #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             dut_rst_n,
    input  logic [1:0]       up_down,
    input  logic [WIDTH-1:0] start_value,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] value_inv,
    output logic [WIDTH-1:0] exp_value,
    output logic             chk_valid,
    output logic             err_value,
    output logic             err_inv,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        CMD_DOWN    = 2'b00,
        CMD_UP      = 2'b01,
        CMD_LOAD    = 2'b10,
        CMD_LOAD_UP = 2'b11
    } cmd_e;

    cmd_e             cmd1_q, cmd2_q;
    logic [WIDTH-1:0] start1_q, val1_q;
    logic             hist_ok_q;
    logic             chk_valid_q, err_value_q, err_inv_q, err_sticky_q;
    logic [ERR_W-1:0] err_count_q, wrap_count_q;

    logic             err_sticky_d;
    logic [ERR_W-1:0] err_count_d, wrap_count_d;
    cmd_e             cmd_in;
    logic [WIDTH-1:0] pred;
    logic             pred_inc, pred_dec;
    logic             compare, value_mismatch, inv_mismatch;
    logic             err_hit, wrap_hit;

    assign cmd_in = cmd_e'(up_down);

    // A held 11 loads once, then counts up on every following 11 cycle.
    assign pred_inc = (cmd1_q == CMD_UP) ||
                      ((cmd1_q == CMD_LOAD_UP) && (cmd2_q == CMD_LOAD_UP));
    assign pred_dec = (cmd1_q == CMD_DOWN);

    always_comb begin
        pred = start1_q;
        if (pred_inc) begin
            pred = val1_q + WIDTH'(1);
        end else if (pred_dec) begin
            pred = val1_q - WIDTH'(1);
        end
    end

    assign exp_value      = hist_ok_q ? pred : '0;
    assign compare        = hist_ok_q && dut_rst_n;
    assign value_mismatch = (value != pred);
    assign inv_mismatch   = (value_inv != ~value);
    assign err_hit        = (compare && value_mismatch) || (dut_rst_n && inv_mismatch);
    assign wrap_hit       = compare && !value_mismatch &&
                            ((pred_inc && (val1_q == '1) && (value == '0)) ||
                             (pred_dec && (val1_q == '0) && (value == '1)));

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        if (clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
            wrap_count_d = '0;
        end else begin
            if (err_hit) begin
                err_sticky_d = 1'b1;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERR_W'(1);
                end
            end
            if (wrap_hit && (wrap_count_q != '1)) begin
                wrap_count_d = wrap_count_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd1_q       <= CMD_DOWN;
            cmd2_q       <= CMD_DOWN;
            start1_q     <= '0;
            val1_q       <= '0;
            hist_ok_q    <= 1'b0;
            chk_valid_q  <= 1'b0;
            err_value_q  <= 1'b0;
            err_inv_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            cmd1_q       <= cmd_in;
            cmd2_q       <= dut_rst_n ? cmd1_q : CMD_DOWN;
            start1_q     <= start_value;
            val1_q       <= value;
            hist_ok_q    <= dut_rst_n;
            chk_valid_q  <= compare;
            err_value_q  <= compare && value_mismatch;
            err_inv_q    <= dut_rst_n && inv_mismatch;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign chk_valid  = chk_valid_q;
    assign err_value  = err_value_q;
    assign err_inv    = err_inv_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Passive in-circuit checker on the output side of the up/down counter.
- Samples the counter's command inputs (up_down, start_value) and its outputs (value, value_inv) every clock.
- Predicts each next value and flags value mismatches, complement (value_inv) mismatches and wrap-arounds.
- Sits beside the counter in integration builds; results go to status/debug registers.

Parameters:
- WIDTH, 8, width of value, value_inv, start_value and exp_value.
- ERR_W, 8, width of err_count and wrap_count.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high checker reset
- clr  in  1  synchronous clear of sticky flags and counters; history is kept
- dut_rst_n  in  1  counter's active-low reset, observed as a level
- up_down  in  2  counter command: 00 down, 01 up, 10 load, 11 load-then-up
- start_value  in  WIDTH  counter load value
- value  in  WIDTH  counter output
- value_inv  in  WIDTH  counter complemented output
- exp_value  out  WIDTH  predicted value for the current sample
- chk_valid  out  1  a comparison was performed at the last edge
- err_value  out  1  one-cycle pulse: value != exp_value
- err_inv  out  1  one-cycle pulse: value_inv != ~value
- err_sticky  out  1  set by any error; cleared by rst or clr
- err_count  out  ERR_W  saturating count of error cycles
- wrap_count  out  ERR_W  saturating count of observed wraps

Behaviour:
- **Reset.** All outputs are 0 after a clk edge with rst=1. History is invalid (hist_ok=0).
- **History.** At every edge the checker registers cmd1<=up_down, cmd2<=cmd1, start1<=start_value, val1<=value.
- **Prediction**, from the previous cycle's registered history (combinational, shown on exp_value):
  - cmd1=00: val1-1, mod 2^WIDTH.
  - cmd1=01: val1+1, mod 2^WIDTH.
  - cmd1=10: start1.
  - cmd1=11 and cmd2!=11: start1 (load on the first 11 cycle).
  - cmd1=11 and cmd2=11: val1+1, mod 2^WIDTH.
- **Compare at edge k** (only when hist_ok=1 and dut_rst_n=1):
  - chk_valid<=1.
  - err_value<=(value!=exp_value).
- **Complement check.** err_inv<=(value_inv!=~value) whenever dut_rst_n=1. It does not depend on hist_ok.
- **Counter in reset.** When dut_rst_n=0 is sampled:
  - chk_valid, err_value and err_inv go to 0.
  - hist_ok<=0.
  - cmd2 is forced to 00, so a following 11 is treated as a fresh load.
- **hist_ok recovery.** hist_ok<=1 at the first edge that samples dut_rst_n=1. The first valid comparison is therefore at the second edge after the counter leaves reset.
- **Error accounting.** On a cycle with err_value|err_inv:
  - err_sticky<=1.
  - err_count increments by 1 per cycle, not per error type; it saturates at 2^ERR_W-1.
- **Wrap detection.** wrap_count increments on a compared cycle with no value error when either:
  - cmd1 is an increment and val1=all-ones, value=0; or
  - cmd1=00 and val1=0, value=all-ones.
  - Loads never count as wraps. wrap_count saturates at 2^ERR_W-1.
- **clr.** Zeroes err_sticky, err_count and wrap_count. History and hist_ok are untouched. If an error or wrap occurs in the same cycle, clr wins.
- **Priority.** rst > dut_rst_n=0 > normal compare.
- **Latency.** All outputs are registered; a fault on sample k is visible one cycle after edge k.

Test Plan:
- rst=1 for 2 cycles, then counter reset released with up_down=10, start=0x32, then up_down=01 for 8 cycles:
  - exp_value tracks 0x32,0x33..0x3A.
  - err_value never asserts; chk_valid=1 from the second post-reset edge.
- Load 0x02, count down 4 cycles (00):
  - Expected sequence 0x01,0x00,0xFF,0xFE.
  - wrap_count=1, no errors.
- Force value_inv=0x00 while value=0x05:
  - err_inv pulses for exactly one cycle per bad sample.
  - err_sticky=1, err_count=1.
  - Then clr=1: flags and counters return to 0.
- Drive up_down=11 with start=0xA0 for 5 cycles:
  - exp_value 0xA0,0xA1..0xA4.
  - Repeat after one 00 cycle: the first 11 reloads 0xA0.
- Inject value=0x40 where 0x3C is expected:
  - err_value pulses once.
  - Next cycle predicts 0x41 (resyncs from observed value).
- Hold a persistent mismatch for 300 cycles with ERR_W=8: err_count saturates at 0xFF.
- Assert dut_rst_n=0 mid-count: chk_valid drops, no errors during reset.
